// File: rtl/hex_word_printer_if.sv
// Handshake bundle for hex_word_printer: word input stream, ASCII byte
// output stream and the busy flag. The printer attaches to the slave modport.
interface hex_word_printer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_char, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_char, busy
  );
endinterface

// File: rtl/hex_word_printer.sv
// hex_word_printer: prints a WIDTH-bit word as hex ASCII, MS nibble first,
// followed by TERM_CHAR. Optional "0x" prefix when HEX_WORD_PRINTER_PREFIX_EN
// is defined. Digits go through a registered nibble-to-ASCII converter, so
// each digit takes a LOOKUP cycle followed by an EMIT cycle.
module hex_word_printer #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
  input  logic              clk,
  input  logic              reset_n,
  hex_word_printer_if.slave bus
);
  localparam int unsigned   NIB      = WIDTH / 4;
  localparam int unsigned   CW       = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("hex_word_printer: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef HEX_WORD_PRINTER_PREFIX_EN
    S_PRE0,
    S_PRE1,
`endif
    S_LOOKUP,
    S_EMIT,
    S_TERM
  } state_t;

`ifdef HEX_WORD_PRINTER_PREFIX_EN
  localparam state_t FIRST_S = S_PRE0;
`else
  localparam state_t FIRST_S = S_LOOKUP;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q, valid_d;
  logic [7:0]       out_char_q, char_d;

  // Nibble-to-ASCII table; B and D are lowercase so they can't be misread as 8/0
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'hA:    c = 8'h41;
      4'hB:    c = 8'h62;
      4'hC:    c = 8'h43;
      4'hD:    c = 8'h64;
      4'hE:    c = 8'h45;
      4'hF:    c = 8'h46;
      default: c = {4'h3, n};
    endcase
    return c;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = FIRST_S;
`ifdef HEX_WORD_PRINTER_PREFIX_EN
      S_PRE0:   if (bus.out_ready) state_d = S_PRE1;
      S_PRE1:   if (bus.out_ready) state_d = S_LOOKUP;
`endif
      S_LOOKUP: state_d = S_EMIT;
      S_EMIT:   if (bus.out_ready) state_d = (cnt_q == '0) ? S_TERM : S_LOOKUP;
      S_TERM:   if (bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode; out_valid/out_char are registered, so their next values
  // are chosen by the state being entered and simply held while stalled.
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE) && reset_n;
    bus.busy      = (state_q != S_IDLE);
    bus.out_valid = out_valid_q;
    bus.out_char  = out_char_q;
    valid_d       = out_valid_q;
    char_d        = out_char_q;
    if (state_d != state_q) begin
      case (state_d)
`ifdef HEX_WORD_PRINTER_PREFIX_EN
        S_PRE0:   begin valid_d = 1'b1; char_d = 8'h30; end
        S_PRE1:   begin valid_d = 1'b1; char_d = 8'h78; end
`endif
        S_LOOKUP: valid_d = 1'b0;
        S_EMIT:   begin valid_d = 1'b1; char_d = hex_ascii(sh_q[WIDTH-1 -: 4]); end
        S_TERM:   begin valid_d = 1'b1; char_d = TERM_CHAR; end
        default:  valid_d = 1'b0;
      endcase
    end
  end

  // Datapath: word shift register, nibble counter, registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
    end else begin
      out_valid_q <= valid_d;
      out_char_q  <= char_d;
      if (state_q == S_IDLE && bus.in_valid) begin
        sh_q  <= bus.in_data;
        cnt_q <= CNT_LAST;
      end else if (state_q == S_EMIT && bus.out_ready) begin
        sh_q <= sh_q << 4;
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_hex_word_printer.sv
// Self-checking bench for hex_word_printer (WIDTH=32 main instance plus a
// WIDTH=8 / space-terminator instance). Honours HEX_WORD_PRINTER_PREFIX_EN.
module tb_hex_word_printer;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hex_word_printer_if #(.WIDTH(32)) ifc ();
  hex_word_printer_if #(.WIDTH(8))  ifc8 ();

  hex_word_printer #(.WIDTH(32), .TERM_CHAR(8'h0A)) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifc)
  );
  hex_word_printer #(.WIDTH(8), .TERM_CHAR(8'h20)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(ifc8)
  );

`ifdef HEX_WORD_PRINTER_PREFIX_EN
  localparam int PFX = 2;
`else
  localparam int PFX = 0;
`endif

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] digits[16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'h41, 8'h62, 8'h43, 8'h64, 8'h45, 8'h46};
  logic       stall_prev = 1'b0;
  logic [7:0] prev_char  = 8'h00;
  logic       last_busy  = 1'b0;
  int         nhs        = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: the text a word must produce
  task automatic push_word(input logic [31:0] d);
    if (PFX != 0) begin exp_q.push_back(8'h30); exp_q.push_back(8'h78); end
    for (int i = 7; i >= 0; i--) exp_q.push_back(digits[d[4*i +: 4]]);
    exp_q.push_back(8'h0A);
  endtask

  // One cycle: sample at negedge, drive inputs for the next posedge, score handshakes
  task automatic step(input logic vin, input logic [31:0] d, input logic rdy);
    logic [7:0] e;
    @(negedge clk);
    last_busy = ifc.busy;
    check("busy", 32'(ifc.busy), 32'(exp_q.size() != 0));
    if (stall_prev) begin
      check("hold_valid", 32'(ifc.out_valid), 32'd1);
      check("hold_char", 32'(ifc.out_char), 32'(prev_char));
    end
    ifc.in_valid  = vin;
    ifc.in_data   = d;
    ifc.out_ready = rdy;
    if (ifc.out_valid && rdy) begin
      nhs++;
      got_q.push_back(ifc.out_char);
      if (exp_q.size() == 0) check("extra_char", 32'(ifc.out_char), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("char", 32'(ifc.out_char), 32'(e));
      end
    end
    stall_prev = ifc.out_valid && !rdy;
    prev_char  = ifc.out_char;
    if (vin && ifc.in_ready) push_word(d);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || ifc.busy) && n < 400) begin
      step(1'b0, 32'h0, 1'b1);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic cmp_got(input string tag, input logic [7:0] ref_q[$]);
    check({tag, "_len"}, 32'(got_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(ref_q[i]));
  endtask

  initial begin
    logic [7:0] r[$];
    int lat;
    int base;
    reset_n = 1'b0;
    ifc.in_valid = 1'b0;  ifc.in_data = '0;  ifc.out_ready = 1'b0;
    ifc8.in_valid = 1'b0; ifc8.in_data = '0; ifc8.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_out_char", 32'(ifc.out_char), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(ifc.in_ready), 32'd1);

    // 1234ABCD, no backpressure: exact text and accept-to-idle latency
    got_q.delete();
    step(1'b1, 32'h1234ABCD, 1'b1);
    lat = 0;
    step(1'b0, 32'h0, 1'b1);
    while (last_busy && lat < 100) begin lat++; step(1'b0, 32'h0, 1'b1); end
    check("latency", 32'(lat), 32'(17 + PFX));
    r = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h62, 8'h43, 8'h64, 8'h0A};
    if (PFX != 0) begin r.push_front(8'h78); r.push_front(8'h30); end
    cmp_got("t1234", r);

    // Leading zeros kept
    step(1'b1, 32'h0000000F, 1'b1);
    drain("drain_0f");

    // DEADBEEF under random backpressure
    step(1'b1, 32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 60; i++) step(1'b0, 32'h0, 1'($urandom_range(0, 1)));
    drain("drain_dead");

    // in_valid held high with changing data while busy
    for (int i = 0; i < 70; i++) step(1'b1, $urandom, 1'($urandom_range(0, 3) != 0));
    drain("drain_held");

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 3) != 0));
    drain("drain_rand");

    // Async reset after third digit, with the fourth digit pending
    step(1'b1, 32'h89ABCDEF, 1'b1);
    base = nhs;
    lat = 0;
    while (nhs < base + 3 + PFX && lat < 100) begin lat++; step(1'b0, 32'h0, 1'b1); end
    check("reset_reach", 32'(nhs), 32'(base + 3 + PFX));
    step(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(ifc.out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(ifc.out_valid), 32'd0);
    check("arst_char", 32'(ifc.out_char), 32'd0);
    check("arst_busy", 32'(ifc.busy), 32'd0);
    check("arst_in_ready", 32'(ifc.in_ready), 32'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    got_q.delete();
    step(1'b1, 32'h00000001, 1'b1);
    drain("drain_post_rst");
    r = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0A};
    if (PFX != 0) begin r.push_front(8'h78); r.push_front(8'h30); end
    cmp_got("t_post_rst", r);

    // WIDTH=8, space terminator
    got_q.delete();
    @(negedge clk);
    ifc8.in_valid = 1'b1; ifc8.in_data = 8'hE5;
    @(negedge clk);
    ifc8.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc8.out_valid) got_q.push_back(ifc8.out_char);
      @(negedge clk);
    end
    r = '{8'h45, 8'h35, 8'h20};
    if (PFX != 0) begin r.push_front(8'h78); r.push_front(8'h30); end
    cmp_got("w8", r);
    check("w8_idle", 32'(ifc8.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
